// File: rtl/addsub_result_stage.sv
// addsub_result_stage
// Result capture stage for the 4-bit adder/subtractor. Each accepted result is
// tagged with zero/negative/overflow flags and queued in a DEPTH-entry FIFO so
// a slower consumer can drain it. A saturating counter tracks accepted results
// with cf set.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready depends on state only)
//   in_y, in_cf, in_op       adder result, carry/borrow, op code (2'b01 = SUB)
//   in_a_msb, in_b_msb       operand sign bits used for overflow
//   out_valid / out_ready    downstream handshake for the head entry
//   out_y, out_cf, out_zf,
//   out_nf, out_vf, out_op   head entry payload
//   clr_cnt                  synchronous clear of cf_count
//   cf_count                 saturating count of accepted results with cf = 1
module addsub_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_y,
    input  logic             in_cf,
    input  logic [1:0]       in_op,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_y,
    output logic             out_cf,
    output logic             out_zf,
    output logic             out_nf,
    output logic             out_vf,
    output logic [1:0]       out_op,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cf_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [1:0]       OP_SUB   = 2'b01;

    typedef struct packed {
        logic [3:0] y;
        logic       cf;
        logic       zf;
        logic       nf;
        logic       vf;
        logic [1:0] op;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_next;
    entry_t             entry_in;
    logic               push;
    logic               pop;
    logic               vf_in;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Overflow: ADD overflows when like-signed operands give a differently
    // signed result; SUB when unlike-signed operands do. Codes 10/11 are ADD.
    always_comb begin
        vf_in = 1'b0;
        if (in_op == OP_SUB) begin
            vf_in = (in_a_msb != in_b_msb) && (in_y[3] != in_a_msb);
        end else begin
            vf_in = (in_a_msb == in_b_msb) && (in_y[3] != in_a_msb);
        end
    end

    always_comb begin
        entry_in    = '0;
        entry_in.y  = in_y;
        entry_in.cf = in_cf;
        entry_in.zf = (in_y == 4'b0000);
        entry_in.nf = in_y[3];
        entry_in.vf = vf_in;
        entry_in.op = in_op;
    end

    // Next occupancy; a pop and a push in the same cycle cancel.
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    // Pointers, occupancy and the registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ       <= occ_next;
            out_valid <= (occ_next != '0);
            in_ready  <= (occ_next < OCC_FULL);
        end
    end

    // Storage; cleared on reset so the head reads as all-zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Head entry payload straight from the storage flops.
    always_comb begin
        out_y  = mem[rd_ptr].y;
        out_cf = mem[rd_ptr].cf;
        out_zf = mem[rd_ptr].zf;
        out_nf = mem[rd_ptr].nf;
        out_vf = mem[rd_ptr].vf;
        out_op = mem[rd_ptr].op;
    end

    // Saturating carry/borrow event counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_count <= '0;
        end else if (clr_cnt) begin
            cf_count <= '0;
        end else if (push && in_cf && (cf_count != '1)) begin
            cf_count <= cf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
module tb_addsub_result_stage;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_y;
    logic             in_cf;
    logic [1:0]       in_op;
    logic             in_a_msb;
    logic             in_b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_y;
    logic             out_cf;
    logic             out_zf;
    logic             out_nf;
    logic             out_vf;
    logic [1:0]       out_op;
    logic             clr_cnt;
    logic [CNT_W-1:0] cf_count;

    int n_vec = 0;
    int n_err = 0;

    addsub_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_cf     (in_cf),
        .in_op     (in_op),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_cf    (out_cf),
        .out_zf    (out_zf),
        .out_nf    (out_nf),
        .out_vf    (out_vf),
        .out_op    (out_op),
        .clr_cnt   (clr_cnt),
        .cf_count  (cf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] y, input logic cf,
                         input logic [1:0] op, input logic a, input logic b);
        in_valid = v;
        in_y     = y;
        in_cf    = cf;
        in_op    = op;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [3:0] y, input logic cf,
                            input logic zf, input logic nf, input logic vf,
                            input logic [1:0] op);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".y"},  32'(out_y),  32'(y));
        chk({tag, ".cf"}, 32'(out_cf), 32'(cf));
        chk({tag, ".zf"}, 32'(out_zf), 32'(zf));
        chk({tag, ".nf"}, 32'(out_nf), 32'(nf));
        chk({tag, ".vf"}, 32'(out_vf), 32'(vf));
        chk({tag, ".op"}, 32'(out_op), 32'(op));
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset / idle
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.cf_count",  32'(cf_count),  32'd0);

        // ADD 8: negative with signed overflow
        out_ready = 1'b1;
        drive(1'b1, 4'h8, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk_head("add8", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("add8.drained", 32'(out_valid), 32'd0);

        // SUB zero result, then SUB 3-4 = F with borrow
        out_ready = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 2'b01, 1'b1, 1'b1);
        step();
        chk_head("sub0", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        out_ready = 1'b1;
        drive(1'b1, 4'hF, 1'b1, 2'b01, 1'b0, 1'b0);
        step();
        chk_head("subF", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        chk("subF.cf_count", 32'(cf_count), 32'd1);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("subF.drained", 32'(out_valid), 32'd0);

        // Fill to full with consumer stalled; third push must be refused
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("full.rdy1", 32'(in_ready), 32'd1);
        drive(1'b1, 4'h2, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("full.rdy2", 32'(in_ready), 32'd0);
        drive(1'b1, 4'h3, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("full.rdy3", 32'(in_ready), 32'd0);
        chk_head("full.hold", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        out_ready = 1'b1;
        step();
        chk("full.pop_rdy", 32'(in_ready), 32'd1);
        chk_head("full.head2", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("full.no3", 32'(out_valid), 32'd0);

        // Streaming push+pop at occupancy 1 across pointer wrap
        drive(1'b1, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] y;
            y = 4'(i);
            drive(1'b1, y, 1'b0, 2'b00, 1'b0, 1'b0);
            step();
            chk_head("stream", y, 1'b0, 1'b0, y[3], y[3], 2'b00);
            chk("stream.rdy", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk("stream.drained", 32'(out_valid), 32'd0);

        // Op codes 10 and 11 behave as ADD for overflow
        out_ready = 1'b0;
        drive(1'b1, 4'h8, 1'b0, 2'b11, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h7, 1'b0, 2'b10, 1'b1, 1'b1);
        step();
        chk_head("op11", 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        chk_head("op10", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        step();
        chk("op.drained", 32'(out_valid), 32'd0);

        // Counter saturation (starts at 1) and clear priority
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'h5, 1'b1, 2'b00, 1'b0, 1'b0);
            step();
        end
        chk("cnt.sat", 32'(cf_count), 32'd255);
        step();
        chk("cnt.hold", 32'(cf_count), 32'd255);
        clr_cnt = 1'b1;
        step();
        chk("cnt.clr", 32'(cf_count), 32'd0);
        clr_cnt = 1'b0;
        step();
        chk("cnt.after_clr", 32'(cf_count), 32'd1);

        // Asynchronous reset mid-cycle with data buffered
        out_ready = 1'b0;
        drive(1'b1, 4'hA, 1'b1, 2'b00, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.cf_count",  32'(cf_count),  32'd0);
        chk("arst.out_y",     32'(out_y),     32'd0);
        chk("arst.in_ready",  32'(in_ready),  32'd1);
        step();
        rst = 1'b0;
        step();
        chk("arst.idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
Downstream stage of the 4-bit adder/subtractor. Captures each combinational result (y, cf) with its op code and operand sign bits. Derives zero, negative and signed-overflow flags, then buffers the result record in a small FIFO with valid/ready handshakes so a slower consumer can drain results. Keeps a saturating count of results whose carry/borrow flag is set.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2.
CNT_W, 8, width of the carry/borrow event counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result is valid this cycle
in_ready  output  1  stage can accept a result this cycle
in_y  input  4  adder result y
in_cf  input  1  adder cf (carry on add, borrow on sub)
in_op  input  2  op code that produced the result (2'b01 = SUB, anything else = ADD)
in_a_msb  input  1  bit 3 of operand a
in_b_msb  input  1  bit 3 of operand b
out_valid  output  1  head FIFO entry valid
out_ready  input  1  consumer accepts head entry
out_y  output  4  buffered result
out_cf  output  1  buffered carry/borrow
out_zf  output  1  result == 0
out_nf  output  1  result bit 3
out_vf  output  1  two's-complement overflow
out_op  output  2  buffered op code
clr_cnt  input  1  synchronous clear of cf_count
cf_count  output  CNT_W  saturating count of accepted results with cf = 1

Behaviour:
- Reset is asynchronous: FIFO emptied and read/write pointers set to 0; occupancy = 0; out_valid = 0; out_y = 0; out_cf/zf/nf/vf = 0; out_op = 0; cf_count = 0. in_ready = 1 once reset deasserts. A reset mid-stream discards every buffered entry.
- Push: accepted when in_valid && in_ready. Pop: occurs when out_valid && out_ready.
- in_ready = (occupancy < DEPTH). It is registered/derived from state only, with no combinational path from out_ready.
- Flags are computed at push and stored with the entry:
  - zf = (in_y == 4'b0000).
  - nf = in_y[3].
  - ADD: vf = (a_msb == b_msb) && (y[3] != a_msb).
  - SUB: vf = (a_msb != b_msb) && (y[3] != a_msb).
- Latency: an entry pushed in cycle N is visible on out_* with out_valid = 1 in cycle N+1. There is no same-cycle bypass.
- out_* reflect the head entry whenever out_valid = 1. They hold stable while out_valid && !out_ready. Values while out_valid = 0 are don't-care; the bench must not check them.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged and both pointers advance.
- Full (occupancy == DEPTH): in_ready = 0 and no push, even if out_ready = 1 in the same cycle. in_ready rises the cycle after a pop.
- Empty: out_valid = 0 and pop requests are ignored.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is a separate register of log2(DEPTH)+1 bits.
- cf_count increments by 1 on each accepted push with in_cf = 1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt = 1 forces it to 0 next edge, overriding a simultaneous increment.
- The op code is interpreted only for the vf calculation. Codes 2'b10 and 2'b11 are treated as ADD.

Test Plan:
- Reset then idle → out_valid = 0, in_ready = 1, cf_count = 0. Assert rst asynchronously mid-cycle → outputs clear immediately, without waiting for a clock edge.
- Push ADD y=4'h8, cf=0, a_msb=0, b_msb=0 with out_ready=1 → next cycle out_valid=1, out_y=8, nf=1, vf=1, zf=0. Pop empties the FIFO the following cycle.
- Push SUB y=4'h0, cf=0, a_msb=1, b_msb=1 → zf=1, vf=0, nf=0, out_op=2'b01. Push SUB y=4'hF, cf=1 (3-4) → nf=1, cf=1, cf_count increments.
- Hold out_ready=0 and push 3 results with DEPTH=2 → in_ready=0 after the 2nd push and the 3rd is not accepted. With out_ready=1 and in_valid=1 while full: only a pop occurs, and in_ready=1 the next cycle. Entries drain in FIFO order with values intact.
- Continuous push+pop for 10 cycles at occupancy 1 → pointer wrap is transparent, occupancy stays 1, and the output sequence equals the input sequence delayed by one cycle.
- 300 pushes with cf=1 (CNT_W=8) → cf_count = 255 and held. Assert clr_cnt together with a cf=1 push → cf_count = 0 next cycle.
